// File: rtl/kcpsm3_intc_pkg.sv
// Shared register offsets, bit positions and helpers for the KCPSM3 interrupt controller.
package kcpsm3_intc_pkg;

  typedef enum logic [1:0] {
    INTC_PEND = 2'd0,
    INTC_MASK = 2'd1,
    INTC_VEC  = 2'd2,
    INTC_CTRL = 2'd3
  } intc_reg_e;

  localparam int unsigned CTRL_GEN_BIT    = 0;
  localparam int unsigned CTRL_IN_SVC_BIT = 1;
  localparam int unsigned VEC_VALID_BIT   = 7;

  function automatic logic [7:0] vec_word(input logic valid, input logic [2:0] id);
    logic [7:0] w;
    w = '0;
    w[VEC_VALID_BIT] = valid;
    w[2:0] = id;
    return w;
  endfunction

endpackage

// File: rtl/kcpsm3_intc_prio.sv
// Lowest-index-wins priority encoder over the active interrupt vector.
module kcpsm3_intc_prio #(
  parameter int unsigned NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               any,
  output logic [2:0]         id
);

  always_comb begin
    any = 1'b0;
    id  = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (req[i] && !any) begin
        any = 1'b1;
        id  = 3'(i);
      end
    end
  end

endmodule

// File: rtl/kcpsm3_intc.sv
// KCPSM3 interrupt controller: pending/mask/vector/ctrl registers on the port_id bus.
// Define KCPSM3_INTC_EDGE_EN for rising-edge source capture; default is level capture.
module kcpsm3_intc
  import kcpsm3_intc_pkg::*;
#(
  parameter int unsigned NUM_SRC   = 8,
  parameter logic [7:0]  BASE_PORT = 8'hE0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src,
  input  logic [7:0]         port_id,
  input  logic               write_strobe,
  input  logic               read_strobe,
  input  logic [7:0]         out_port,
  output logic [7:0]         rd_data,
  output logic               interrupt,
  input  logic               interrupt_ack
);

  logic [NUM_SRC-1:0] pend, mask, active, set_req, pend_nxt;
  logic               gen, in_svc, vec_valid;
  logic [2:0]         vec_id;
  logic               win_any;
  logic [2:0]         win_id;
  logic               hit, wr_pend, wr_mask, wr_vec, wr_ctrl;
  intc_reg_e          reg_sel;
  logic [7:0]         rd_nxt;
  logic               unused_bits;

  assign unused_bits = ^{read_strobe, out_port};

  assign reg_sel = intc_reg_e'(port_id[1:0]);
  assign hit     = (port_id[7:2] == BASE_PORT[7:2]);
  assign wr_pend = write_strobe && hit && (reg_sel == INTC_PEND);
  assign wr_mask = write_strobe && hit && (reg_sel == INTC_MASK);
  assign wr_vec  = write_strobe && hit && (reg_sel == INTC_VEC);
  assign wr_ctrl = write_strobe && hit && (reg_sel == INTC_CTRL);

  assign active = pend & mask;

  kcpsm3_intc_prio #(
    .NUM_SRC(NUM_SRC)
  ) u_prio (
    .req(active),
    .any(win_any),
    .id (win_id)
  );

`ifdef KCPSM3_INTC_EDGE_EN
  logic [NUM_SRC-1:0] src_hist;

  always_ff @(posedge clk) begin
    if (reset) src_hist <= '0;
    else       src_hist <= src;
  end

  assign set_req = src & ~src_hist;
`else
  assign set_req = src;
`endif

  // Clears first, then sets, so a source request beats W1C and ack-clear on the same bit.
  always_comb begin
    pend_nxt = pend;
    if (wr_pend) pend_nxt = pend_nxt & ~out_port[NUM_SRC-1:0];
    if (interrupt_ack && win_any) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (win_id == 3'(i)) pend_nxt[i] = 1'b0;
      end
    end
    pend_nxt = pend_nxt | set_req;
  end

  always_comb begin
    rd_nxt = '0;
    if (hit) begin
      case (reg_sel)
        INTC_PEND: rd_nxt[NUM_SRC-1:0] = pend;
        INTC_MASK: rd_nxt[NUM_SRC-1:0] = mask;
        INTC_VEC:  rd_nxt = vec_word(vec_valid, vec_id);
        INTC_CTRL: begin
          rd_nxt[CTRL_GEN_BIT]    = gen;
          rd_nxt[CTRL_IN_SVC_BIT] = in_svc;
        end
        default:   rd_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend      <= '0;
      mask      <= '0;
      gen       <= 1'b0;
      in_svc    <= 1'b0;
      vec_valid <= 1'b0;
      vec_id    <= '0;
      interrupt <= 1'b0;
      rd_data   <= '0;
    end else begin
      pend    <= pend_nxt;
      rd_data <= rd_nxt;
      if (wr_mask) mask <= out_port[NUM_SRC-1:0];
      if (wr_ctrl) gen  <= out_port[CTRL_GEN_BIT];
      // Ack takes precedence over a same-cycle EOI write.
      if (interrupt_ack) begin
        in_svc    <= 1'b1;
        vec_valid <= win_any;
        vec_id    <= win_any ? win_id : 3'd0;
      end else if (wr_vec) begin
        in_svc    <= 1'b0;
        vec_valid <= 1'b0;
        vec_id    <= '0;
      end
      // Masking with the ack drops the request in the cycle right after acknowledge.
      interrupt <= gen && (|active) && !in_svc && !interrupt_ack;
    end
  end

endmodule

// File: tb/tb_kcpsm3_intc.sv
// Directed table-driven bench for kcpsm3_intc plus hand-written edge/level and reset sequences.
module tb_kcpsm3_intc;

  localparam logic [7:0] PEND_P = 8'hE0;
  localparam logic [7:0] MASK_P = 8'hE1;
  localparam logic [7:0] VEC_P  = 8'hE2;
  localparam logic [7:0] CTRL_P = 8'hE3;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] src, port_id, out_port, rd_data;
  logic       write_strobe, read_strobe, interrupt, interrupt_ack;

  always #5 clk = ~clk;

  kcpsm3_intc #(
    .NUM_SRC  (8),
    .BASE_PORT(8'hE0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .src          (src),
    .port_id      (port_id),
    .write_strobe (write_strobe),
    .read_strobe  (read_strobe),
    .out_port     (out_port),
    .rd_data      (rd_data),
    .interrupt    (interrupt),
    .interrupt_ack(interrupt_ack)
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  typedef enum {OP_WR, OP_RD, OP_ACK, OP_INT, OP_IDLE} op_e;
  typedef struct {
    op_e        op;
    logic [7:0] port;
    logic [7:0] data;
    logic [7:0] srcv;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic void add(input op_e op, input logic [7:0] port, input logic [7:0] data,
                              input logic [7:0] srcv, input logic [7:0] exp);
    vec_t v;
    v.op = op; v.port = port; v.data = data; v.srcv = srcv; v.exp = exp;
    tbl.push_back(v);
  endfunction

  function automatic void wr(input logic [7:0] p, input logic [7:0] d, input logic [7:0] s);
    add(OP_WR, p, d, s, 8'h00);
  endfunction
  function automatic void rd(input logic [7:0] p, input logic [7:0] e);
    add(OP_RD, p, 8'h00, 8'h00, e);
  endfunction
  function automatic void rds(input logic [7:0] p, input logic [7:0] e, input logic [7:0] s);
    add(OP_RD, p, 8'h00, s, e);
  endfunction
  function automatic void ack();
    add(OP_ACK, 8'h00, 8'h00, 8'h00, 8'h00);
  endfunction
  function automatic void ichk(input logic e);
    add(OP_INT, 8'h00, 8'h00, 8'h00, {7'b0, e});
  endfunction
  function automatic void idle(input logic [7:0] s);
    add(OP_IDLE, 8'h00, 8'h00, s, 8'h00);
  endfunction

  task automatic run_row(input int idx, input vec_t v);
    case (v.op)
      OP_WR: begin
        src = v.srcv; port_id = v.port; out_port = v.data; write_strobe = 1'b1;
        tick();
        write_strobe = 1'b0;
      end
      OP_RD: begin
        src = v.srcv; port_id = v.port; read_strobe = 1'b1;
        tick();
        check($sformatf("row%0d_rd_%02h", idx, v.port), rd_data, v.exp);
        read_strobe = 1'b0;
      end
      OP_ACK: begin
        src = v.srcv; interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
      end
      OP_INT: check($sformatf("row%0d_interrupt", idx), {7'b0, interrupt}, v.exp);
      default: begin
        src = v.srcv;
        tick();
      end
    endcase
  endtask

  task automatic rd_now(input string name, input logic [7:0] p, input logic [7:0] e);
    port_id = p; read_strobe = 1'b1;
    tick();
    check(name, rd_data, e);
    read_strobe = 1'b0;
  endtask

  task automatic wr_now(input logic [7:0] p, input logic [7:0] d);
    port_id = p; out_port = d; write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
  endtask

  initial begin
    logic [7:0] lvl_exp;
    reset = 1'b1; src = '0; port_id = '0; out_port = '0;
    write_strobe = 1'b0; read_strobe = 1'b0; interrupt_ack = 1'b0;
    @(negedge clk);
    repeat (3) tick();
    reset = 1'b0;

    // reset state
    ichk(1'b0);
    rd(PEND_P, 8'h00); rd(MASK_P, 8'h00); rd(VEC_P, 8'h00); rd(CTRL_P, 8'h00);
    // single source, two-cycle latency, ack and EOI
    wr(MASK_P, 8'h04, 8'h00); wr(CTRL_P, 8'h01, 8'h00);
    idle(8'h04); ichk(1'b0);
    idle(8'h00); ichk(1'b1);
    ack(); ichk(1'b0);
    rd(VEC_P, 8'h82); rd(PEND_P, 8'h00); rd(CTRL_P, 8'h03); ichk(1'b0);
    wr(VEC_P, 8'h00, 8'h00);
    rd(VEC_P, 8'h00); rd(CTRL_P, 8'h01); ichk(1'b0);
    // priority between sources 1 and 5
    wr(MASK_P, 8'hFF, 8'h00);
    idle(8'h22); idle(8'h00); ichk(1'b1);
    ack(); rd(VEC_P, 8'h81); rd(PEND_P, 8'h20); ichk(1'b0);
    wr(VEC_P, 8'h00, 8'h00); ichk(1'b0);
    idle(8'h00); ichk(1'b1);
    ack(); rd(VEC_P, 8'h85); rd(PEND_P, 8'h00);
    wr(VEC_P, 8'h00, 8'h00);
    // masking and in-service hold-off
    wr(MASK_P, 8'h00, 8'h00);
    idle(8'h01); idle(8'h00); rd(PEND_P, 8'h01); ichk(1'b0);
    wr(MASK_P, 8'h01, 8'h00); ichk(1'b0);
    idle(8'h00); ichk(1'b1);
    ack(); ichk(1'b0); rd(VEC_P, 8'h80);
    wr(MASK_P, 8'h03, 8'h00);
    idle(8'h02); idle(8'h00); rd(PEND_P, 8'h02); ichk(1'b0);
    wr(VEC_P, 8'h00, 8'h00);
    idle(8'h00); ichk(1'b1);
    ack(); rd(VEC_P, 8'h81);
    // set beats W1C; spurious ack while vector is valid
    wr(PEND_P, 8'h08, 8'h08); rd(PEND_P, 8'h08); ichk(1'b0);
    wr(PEND_P, 8'h08, 8'h00); rd(PEND_P, 8'h00);
    ack(); rd(VEC_P, 8'h00); rd(CTRL_P, 8'h03); ichk(1'b0);
    wr(VEC_P, 8'h00, 8'h00); rd(CTRL_P, 8'h01);
    // address decode
    wr(8'hE5, 8'hFF, 8'h00); rd(MASK_P, 8'h03);
    rd(8'h61, 8'h00); rd(8'hE4, 8'h00);
    // held source: mask off so nothing interrupts, keep src[0] high through W1C and readback
    wr(MASK_P, 8'h00, 8'h00);

    for (int i = 0; i < tbl.size(); i++) run_row(i, tbl[i]);

    // edge versus level capture
    src = 8'h01;
    repeat (10) tick();
    wr_now(PEND_P, 8'h01);
`ifdef KCPSM3_INTC_EDGE_EN
    lvl_exp = 8'h00;
`else
    lvl_exp = 8'h01;
`endif
    rd_now("held_src_w1c", PEND_P, lvl_exp);
    rd_now("held_src_w1c_later", PEND_P, lvl_exp);
    src = 8'h00;
    tick();
    wr_now(PEND_P, 8'h01);
    rd_now("src_released_w1c", PEND_P, 8'h00);

    // reset while interrupt is asserted
    wr_now(MASK_P, 8'h01);
    wr_now(CTRL_P, 8'h01);
    src = 8'h01; tick(); src = 8'h00; tick();
    check("pre_reset_interrupt", {7'b0, interrupt}, 8'h01);
    reset = 1'b1;
    tick();
    check("reset_interrupt", {7'b0, interrupt}, 8'h00);
    check("reset_rd_data", rd_data, 8'h00);
    reset = 1'b0;
    rd_now("reset_pend", PEND_P, 8'h00);
    rd_now("reset_mask", MASK_P, 8'h00);
    rd_now("reset_vec", VEC_P, 8'h00);
    rd_now("reset_ctrl", CTRL_P, 8'h00);
    tick();
    check("reset_int_stays_low", {7'b0, interrupt}, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
